// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues single outstanding reads to instruction memory
// and buffers returned words with their PC in a small FIFO drained by decode.
module instr_fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PC_WIDTH    = 5,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_enable,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr_data,
  output logic [PC_WIDTH-1:0]      instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, req_pc_q;
  logic [INSTR_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem_q   [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_after;
  logic                   push, pop, issue;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect takes priority over everything else
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && issue) state_d = StWait;
      end
      StWait: begin
        if (redirect_valid)   state_d = imem_rvalid ? StIdle : StFlush;
        else if (imem_rvalid) state_d = issue ? StWait : StIdle;
      end
      StFlush: begin
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and handshake decode. Issue reserves a FIFO slot, so a push never hits a full FIFO.
  // Gating with reset keeps imem_req low while reset is held.
  always_comb begin
    push        = (state_q == StWait) && imem_rvalid && !redirect_valid;
    pop         = (count_q != '0) && instr_ready && !redirect_valid;
    count_after = count_q + CntW'(push) - CntW'(pop);
    issue       = reset && fetch_enable && !redirect_valid &&
                  (count_after < CntW'(DEPTH)) &&
                  ((state_q == StIdle) || ((state_q == StWait) && imem_rvalid));
    imem_req    = issue;
    imem_addr   = issue ? pc_q : req_pc_q;
    instr_valid = (count_q != '0);
    instr_data  = data_mem_q[rd_ptr_q];
    instr_pc    = pc_mem_q[rd_ptr_q];
    fill_level  = count_q;
  end

  // PC, request tracking and FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      if (redirect_valid) pc_q <= redirect_pc;
      else if (issue)     pc_q <= pc_q + 1'b1;
      if (issue) req_pc_q <= pc_q;
      if (redirect_valid) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q <= count_after;
        if (push) begin
          data_mem_q[wr_ptr_q] <= imem_rdata;
          pc_mem_q[wr_ptr_q]   <= req_pc_q;
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency memory that returns 32'hA0 + addr.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [4:0]  instr_pc;
  logic        instr_ready;
  logic [2:0]  fill_level;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  instr_fetch_queue #(
    .DEPTH      (4),
    .PC_WIDTH   (5),
    .INSTR_WIDTH(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_enable  (fetch_enable),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .fill_level    (fill_level)
  );

  always #5 clk = ~clk;

  // Memory model: request seen in cycle N answers in cycle N+mem_lat; survives DUT reset.
  logic       req_prev  = 1'b0;
  logic [4:0] addr_prev = '0;
  always @(negedge clk) begin
    req_prev  <= imem_req && reset;
    addr_prev <= imem_addr;
  end

  always begin
    static bit       pending = 1'b0;
    static int       cnt     = 0;
    static bit [4:0] paddr   = '0;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (req_prev) begin
      pending = 1'b1;
      paddr   = addr_prev;
      cnt     = mem_lat;
    end
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA0 + 32'(paddr);
        pending     = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    fetch_enable   = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    fetch_enable   = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL reset imem_req: got %b expected 0", imem_req); end
    n_checks++; if (imem_addr !== 5'd0) begin n_fail++;
      $display("FAIL reset imem_addr: got %0d expected 0", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset instr_valid: got %b expected 0", instr_valid); end
    n_checks++; if (instr_data !== 32'd0) begin n_fail++;
      $display("FAIL reset instr_data: got %h expected 0", instr_data); end
    n_checks++; if (instr_pc !== 5'd0) begin n_fail++;
      $display("FAIL reset instr_pc: got %0d expected 0", instr_pc); end
    n_checks++; if (fill_level !== 3'd0) begin n_fail++;
      $display("FAIL reset fill_level: got %0d expected 0", fill_level); end
  endtask

  task automatic test_streaming();
    mem_lat = 1;
    do_reset();
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'(k)) begin n_fail++;
        $display("FAIL stream req c%0d: got req=%b addr=%0d expected req=1 addr=%0d",
                 k, imem_req, imem_addr, k); end
      if (k < 2) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++;
          $display("FAIL stream early valid c%0d: got %b expected 0", k, instr_valid); end
      end else begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'(k - 2) ||
            instr_data !== 32'(32'hA0 + k - 2)) begin
          n_fail++;
          $display("FAIL stream head c%0d: got v=%b pc=%0d d=%h expected v=1 pc=%0d d=%h", k,
                   instr_valid, instr_pc, instr_data, k - 2, 32'(32'hA0 + k - 2));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_pressure();
    mem_lat = 1;
    do_reset();
    fetch_enable = 1'b1;
    instr_ready  = 1'b0;
    repeat (8) next_cycle();
    sample();
    n_checks++; if (fill_level !== 3'd4) begin n_fail++;
      $display("FAIL bp fill_level: got %0d expected 4", fill_level); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL bp imem_req when full: got %b expected 0", imem_req); end
    next_cycle();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (k == 0) begin
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd4) begin n_fail++;
          $display("FAIL bp resume req: got req=%b addr=%0d expected req=1 addr=4",
                   imem_req, imem_addr); end
      end
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 5'(k) || instr_data !== 32'(32'hA0 + k)) begin
        n_fail++;
        $display("FAIL bp order %0d: got v=%b pc=%0d d=%h expected v=1 pc=%0d d=%h", k,
                 instr_valid, instr_pc, instr_data, k, 32'(32'hA0 + k));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    do_reset();
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    repeat (7) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 5'd20;
    sample();
    n_checks++; if (instr_pc !== 5'd1 || imem_req !== 1'b0) begin n_fail++;
      $display("FAIL rw redirect cycle: got pc=%0d req=%b expected pc=1 req=0",
               instr_pc, imem_req); end
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    n_checks++; if (fill_level !== 3'd0 || instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL rw flush: got fill=%0d v=%b expected fill=0 v=0", fill_level, instr_valid);
    end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL rw req in flush: got %b expected 0", imem_req); end
    next_cycle();
    sample();
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 5'd2) begin n_fail++;
      $display("FAIL rw stale drop: got req=%b addr=%0d expected req=0 addr=2",
               imem_req, imem_addr); end
    next_cycle();
    sample();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd20) begin n_fail++;
      $display("FAIL rw new req: got req=%b addr=%0d expected req=1 addr=20",
               imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++;
        $display("FAIL rw stale data %0d: got v=%b pc=%0d expected v=0", k, instr_valid,
                 instr_pc); end
    end
    next_cycle();
    sample();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 5'd20 || instr_data !== 32'hB4) begin n_fail++;
      $display("FAIL rw target head: got v=%b pc=%0d d=%h expected v=1 pc=20 d=000000b4",
               instr_valid, instr_pc, instr_data); end
  endtask

  task automatic test_redirect_rvalid();
    mem_lat = 1;
    do_reset();
    fetch_enable = 1'b1;
    instr_ready  = 1'b0;
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 5'd10;
    instr_ready    = 1'b1;
    sample();
    n_checks++; if (fill_level !== 3'd2 || imem_req !== 1'b0) begin n_fail++;
      $display("FAIL rr before: got fill=%0d req=%b expected fill=2 req=0",
               fill_level, imem_req); end
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    n_checks++; if (fill_level !== 3'd0 || instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL rr flushed: got fill=%0d v=%b expected fill=0 v=0", fill_level,
               instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd10) begin n_fail++;
      $display("FAIL rr next req: got req=%b addr=%0d expected req=1 addr=10",
               imem_req, imem_addr); end
    repeat (2) next_cycle();
    sample();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 5'd10 || instr_data !== 32'hAA) begin n_fail++;
      $display("FAIL rr head: got v=%b pc=%0d d=%h expected v=1 pc=10 d=000000aa",
               instr_valid, instr_pc, instr_data); end
  endtask

  task automatic test_pc_wrap();
    logic [4:0]  exp_pc   [3];
    logic [31:0] exp_data [3];
    exp_pc   = '{5'd31, 5'd0, 5'd1};
    exp_data = '{32'hBF, 32'hA0, 32'hA1};
    mem_lat = 1;
    do_reset();
    fetch_enable   = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 5'd31;
    sample();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL wrap req on redirect: got %b expected 0", imem_req); end
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd31) begin n_fail++;
      $display("FAIL wrap addr31: got req=%b addr=%0d expected req=1 addr=31",
               imem_req, imem_addr); end
    next_cycle();
    sample();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin n_fail++;
      $display("FAIL wrap addr0: got req=%b addr=%0d expected req=1 addr=0",
               imem_req, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr_data !== exp_data[k]) begin
        n_fail++;
        $display("FAIL wrap head %0d: got v=%b pc=%0d d=%h expected v=1 pc=%0d d=%h", k,
                 instr_valid, instr_pc, instr_data, exp_pc[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    do_reset();
    fetch_enable = 1'b1;
    instr_ready  = 1'b1;
    repeat (7) next_cycle();
    sample();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd1 || imem_addr !== 5'd2) begin
      n_fail++;
      $display("FAIL ar pre: got v=%b pc=%0d addr=%0d expected v=1 pc=1 addr=2",
               instr_valid, instr_pc, imem_addr); end
    #2;
    reset        = 1'b0;
    fetch_enable = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 5'd0 || instr_valid !== 1'b0 ||
        instr_data !== 32'd0 || instr_pc !== 5'd0 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL ar immediate: got req=%b addr=%0d v=%b d=%h pc=%0d fill=%0d expected 0s",
               imem_req, imem_addr, instr_valid, instr_data, instr_pc, fill_level);
    end
    next_cycle();
    reset = 1'b1;
    repeat (2) next_cycle();
    sample();
    n_checks++; if (fill_level !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ar late rvalid: got fill=%0d v=%b req=%b expected 0 0 0",
               fill_level, instr_valid, imem_req); end
    next_cycle();
    fetch_enable = 1'b1;
    sample();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin n_fail++;
      $display("FAIL ar restart: got req=%b addr=%0d expected req=1 addr=0",
               imem_req, imem_addr); end
    repeat (4) next_cycle();
    sample();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr_data !== 32'hA0) begin n_fail++;
      $display("FAIL ar first head: got v=%b pc=%0d d=%h expected v=1 pc=0 d=000000a0",
               instr_valid, instr_pc, instr_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_pc_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage directly upstream of the decode stage. It owns the 5-bit program counter, issues one-at-a-time reads to instruction memory, and buffers returned 32-bit instruction words with their PC in a small FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect input (jump/branch from decode/execute) reloads the PC and discards everything in flight.

## Interface
- DEPTH, 4, FIFO entries (power of two, 2..16)
- PC_WIDTH, 5, program counter / instruction address width
- INSTR_WIDTH, 32, instruction word width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; all state cleared while low
- fetch_enable  input  1  permits issuing new memory requests
- imem_req  output  1  single-cycle read request pulse
- imem_addr  output  PC_WIDTH  address for imem_req; holds the last issued address otherwise
- imem_rvalid  input  1  read data valid, in order, any number of cycles after imem_req (min 1)
- imem_rdata  input  INSTR_WIDTH  read data, sampled when imem_rvalid=1
- redirect_valid  input  1  one-cycle PC reload and flush
- redirect_pc  input  PC_WIDTH  new PC
- instr_valid  output  1  FIFO head valid
- instr_data  output  INSTR_WIDTH  FIFO head instruction
- instr_pc  output  PC_WIDTH  PC of FIFO head
- instr_ready  input  1  decode accepts head this cycle
- fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State machine: IDLE (no request outstanding), WAIT (one request outstanding, response kept), FLUSH (one request outstanding, response to be dropped).
- Issue condition: state is IDLE, or WAIT with imem_rvalid=1 this cycle; fetch_enable=1; redirect_valid=0; occupancy after this cycle's push/pop < DEPTH. On issue: imem_req=1, imem_addr=pc, req_pc<=pc, pc<=pc+1 (wraps 31->0), state->WAIT.
- WAIT with imem_rvalid=1: push {req_pc, imem_rdata}; state->IDLE unless a new issue occurs the same cycle (then stays WAIT).
- imem_rvalid in IDLE is ignored.
- Pop: instr_valid && instr_ready. instr_valid = (fill_level != 0); instr_data/instr_pc are the head entry, driven from registered storage.
- Push and pop in the same cycle are legal at any occupancy; a full FIFO cannot receive a push because issue reserves the slot.
- Redirect (highest priority): FIFO cleared (fill_level<=0, instr_valid low next cycle, pop this cycle ignored), pc<=redirect_pc, no issue this cycle. Next state: WAIT->FLUSH; WAIT with imem_rvalid the same cycle -> IDLE (response dropped); IDLE->IDLE; FLUSH->FLUSH.
- FLUSH with imem_rvalid=1: data dropped, state->IDLE, no issue that cycle.
- fetch_enable low stops new issues only; an outstanding response is still pushed, and the FIFO still drains.

## Timing
- Reset values: imem_req 0, imem_addr 0, instr_valid 0, instr_data 0, instr_pc 0, fill_level 0; internal pc 0, state IDLE.
- First issue: first rising edge after reset deasserts with fetch_enable=1 (imem_req high in that cycle, addr 0).
- With 1-cycle memory latency: req in cycle N, rvalid in N+1 (pushed at end of N+1), instr_valid high in N+2; the next req is issued in N+1, giving one instruction per cycle when decode is always ready.
- Redirect in cycle N: first request to redirect_pc in N+1 if IDLE; otherwise one cycle after the stale response is dropped.
- Reset asserted mid-transfer: the outstanding request is forgotten, and a later imem_rvalid arrives in IDLE and is ignored.

## Test plan
- Streaming: 1-cycle memory returning 32'h0000_00A0+addr, instr_ready=1 -> decode sees PCs 0,1,2,3... with data A0,A1,A2,A3 on consecutive cycles, first instr_valid 2 cycles after first imem_req.
- Back-pressure: instr_ready=0 -> exactly 4 words buffered (fill_level=4), imem_req stays low. Raise ready -> order is preserved and issue resumes.
- Redirect in WAIT with 3-cycle memory: redirect_pc=5'd20 while the addr-2 request is outstanding -> addr-2 data never appears, fill_level=0 the next cycle, and the next imem_addr is 20 only after the stale rvalid.
- Redirect coincident with rvalid, and with a pop at fill_level=2 -> nothing is pushed, fill_level=0, and the next request goes to redirect_pc the following cycle.
- PC wrap: redirect_pc=31 -> instr_pc sequence 31,0,1.
- Async reset pulse mid-WAIT -> all outputs 0 immediately, the late rvalid is ignored, and fetch restarts at addr 0.
